// File: rtl/ins_loader.sv
// Program loader: parses A5/LEN_LO/LEN_HI/data/CHK frames and writes each data byte into instruction memory.
// Latency: 3 cycles per data byte (transfer, setup, strobe); header and CHK bytes take 1 cycle each.
// Backpressure: rx_ready is low in SETUP and STROBE, so a continuously valid stream is never lost or duplicated.
module ins_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BYTES  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] inject_addr,
    output logic [7:0]            inject_data,
    output logic                  inject_clock,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_SETUP,
        S_STROBE,
        S_CHECK
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_BYTES);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [15:0]           count;
    logic [15:0]           count_inc;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [7:0]            sum;
    logic [15:0]           len_in;
    logic                  len_bad;

    // The write strobe is framed by SETUP/STROBE; no byte may be taken while it is in flight.
    assign rx_ready  = (state != S_SETUP) && (state != S_STROBE);
    assign len_in    = {rx_data, len_lo};
    assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > MAX_LEN);
    assign count_inc = count + 16'd1;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; every state that accepts a byte advances only on a valid byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rx_valid && rx_data == 8'hA5) state_nxt = S_LEN_LO;
            S_LEN_LO: if (rx_valid) state_nxt = S_LEN_HI;
            S_LEN_HI: if (rx_valid) state_nxt = len_bad ? S_IDLE : S_DATA;
            S_DATA:   if (rx_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: state_nxt = (count_inc == len) ? S_CHECK : S_DATA;
            S_CHECK:  if (rx_valid) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length capture, write address/data, strobe, checksum and sticky status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_lo       <= 8'd0;
            len          <= 16'd0;
            count        <= 16'd0;
            addr_cnt     <= '0;
            sum          <= 8'd0;
            inject_addr  <= '0;
            inject_data  <= 8'd0;
            inject_clock <= 1'b0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == 8'hA5) begin
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) len_lo <= rx_data;
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        if (len_bad) begin
                            load_error <= 1'b1;
                        end else begin
                            len      <= len_in;
                            count    <= 16'd0;
                            addr_cnt <= '0;
                            sum      <= 8'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        inject_data <= rx_data;
                        inject_addr <= addr_cnt;
                        sum         <= sum + rx_data;
                    end
                end
                S_SETUP: begin
                    inject_clock <= 1'b1;
                end
                S_STROBE: begin
                    inject_clock <= 1'b0;
                    count        <= count_inc;
                    addr_cnt     <= addr_cnt + ADDR_WIDTH'(1);
                end
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ins_loader.sv
// Testbench for ins_loader: frame-level reference model feeds a scoreboard of expected writes and flags.
// Stimulus driven #1 after the rising edge; all DUT sampling on the falling edge.
// Random valid gaps except in the full-size streaming run, where rx_valid stays high.
module tb_ins_loader;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [9:0] inject_addr;
    logic [7:0] inject_data;
    logic       inject_clock;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;

    ins_loader #(.ADDR_WIDTH(10), .MAX_BYTES(1024)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .inject_addr(inject_addr), .inject_data(inject_data), .inject_clock(inject_clock),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];      // expected memory writes, in order
    logic [2:0] flag_q[$];    // expected {load_done, load_error, cpu_hold} after each frame end
    logic [7:0] stream_q[$];  // bytes to send
    bit         last_q[$];    // byte ends a frame (flags settle on its transfer edge)
    int         waits_q[$];   // falling edges each byte waited before acceptance
    logic [7:0] fdata[$];     // payload for the next frame
    bit         cur_last = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected write on each strobe rise, an expected flag set after each frame end.
    initial begin : monitor
        wr_t        e;
        wr_t        cur_wr;
        logic [2:0] f;
        bit         ic_prev = 1'b0;
        bit         pend = 1'b0;
        logic [9:0] addr_prev = 10'd0;
        logic [7:0] data_prev = 8'd0;
        cur_wr = '0;
        forever begin
            @(negedge clock);
            if (pend) begin
                pend = 1'b0;
                if (flag_q.size() == 0) begin
                    check("flags_unexpected", 32'd1, 32'd0);
                end else begin
                    f = flag_q.pop_front();
                    check("flags", 32'({load_done, load_error, cpu_hold}), 32'(f));
                end
            end
            if (inject_clock && !ic_prev) begin
                if (wr_q.size() == 0) begin
                    check("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    cur_wr = e;
                    check("wr_addr", 32'(inject_addr), 32'(e.addr));
                    check("wr_data", 32'(inject_data), 32'(e.data));
                    check("setup_addr", 32'(addr_prev), 32'(e.addr));
                    check("setup_data", 32'(data_prev), 32'(e.data));
                end
            end
            if (!inject_clock && ic_prev) begin
                check("hold_addr", 32'(inject_addr), 32'(cur_wr.addr));
                check("hold_data", 32'(inject_data), 32'(cur_wr.data));
            end
            if (!reset && rx_valid && rx_ready && cur_last) pend = 1'b1;
            ic_prev   = inject_clock;
            addr_prev = inject_addr;
            data_prev = inject_data;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit l);
        stream_q.push_back(b);
        last_q.push_back(l);
    endtask

    // Frame model: payload byte i lands at address i; load succeeds iff CHK equals the payload sum mod 256.
    task automatic add_frame(input logic [7:0] chk_xor);
        int          n;
        logic [15:0] n16;
        logic [7:0]  s;
        n   = fdata.size();
        n16 = 16'(n);
        s   = 8'd0;
        push_byte(8'hA5, 1'b0);
        push_byte(n16[7:0], 1'b0);
        push_byte(n16[15:8], 1'b0);
        for (int i = 0; i < n; i++) begin
            push_byte(fdata[i], 1'b0);
            wr_q.push_back('{addr: 10'(i), data: fdata[i]});
            s = s + fdata[i];
        end
        push_byte(s ^ chk_xor, 1'b1);
        flag_q.push_back((chk_xor == 8'd0) ? 3'b100 : 3'b011);
        fdata.delete();
    endtask

    // Header with an illegal length: error after LEN_HI, no writes.
    task automatic add_badlen(input logic [15:0] n);
        push_byte(8'hA5, 1'b0);
        push_byte(n[7:0], 1'b0);
        push_byte(n[15:8], 1'b1);
        flag_q.push_back(3'b011);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, output int waits);
        rx_data  = b;
        rx_valid = 1'b1;
        cur_last = last;
        waits    = 0;
        forever begin
            @(negedge clock);
            waits++;
            if (rx_ready) break;
            if (waits >= 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_stream(input bit hold_valid);
        int w;
        waits_q.delete();
        for (int i = 0; i < stream_q.size(); i++) begin
            if (!hold_valid && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
            send_byte(stream_q[i], last_q[i], w);
            waits_q.push_back(w);
        end
        rx_valid = 1'b0;
        cur_last = 1'b0;
        stream_q.delete();
        last_q.delete();
        repeat (8) @(posedge clock);
        #1;
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        check("flags_drained", 32'(flag_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_addr", 32'(inject_addr), 32'd0);
        check("rst_data", 32'(inject_data), 32'd0);
        check("rst_strobe", 32'(inject_clock), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int bad_rate;
        int w;
        // Reset with random input activity.
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            rx_data  = 8'($urandom);
            rx_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_reset_outputs();
        end
        rx_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Good load: A5 04 00 13 00 00 00 13.
        fdata = '{8'h13, 8'h00, 8'h00, 8'h00};
        add_frame(8'h00);
        run_stream(1'b0);
        check("good_done", 32'(load_done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum: A5 01 00 FF 00.
        fdata = '{8'hFF};
        add_frame(8'hFF);
        run_stream(1'b0);
        check("badchk_error", 32'(load_error), 32'd1);

        // Bad lengths: N = 0 and N = 1025.
        add_badlen(16'd0);
        add_badlen(16'd1025);
        run_stream(1'b0);

        // Full-size streaming with leading garbage, rx_valid held high.
        push_byte(8'h00, 1'b0);
        push_byte(8'hFF, 1'b0);
        for (int i = 0; i < 1024; i++) fdata.push_back(8'(i));
        add_frame(8'h00);
        run_stream(1'b1);
        bad_rate = 0;
        for (int i = 0; i < waits_q.size(); i++) begin
            if (waits_q[i] != ((i >= 6) ? 3 : 1)) bad_rate++;
        end
        check("stream_rate", 32'(bad_rate), 32'd0);
        check("stream_done", 32'(load_done), 32'd1);

        // Random mix of frames, garbage and bad headers with random valid gaps.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) == 0) push_byte(8'($urandom_range(0, 8'hA4)), 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                add_badlen(($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(1025, 65535)));
            end else begin
                for (int i = 0; i < $urandom_range(1, 24); i++) fdata.push_back(8'($urandom));
                add_frame(($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
        end
        run_stream(1'b0);

        // Reset while strobing the second byte of a 4-byte frame.
        wr_q.push_back('{addr: 10'd0, data: 8'h3C});
        send_byte(8'hA5, 1'b0, w);
        send_byte(8'h04, 1'b0, w);
        send_byte(8'h00, 1'b0, w);
        send_byte(8'h3C, 1'b0, w);
        send_byte(8'hC3, 1'b0, w);
        rx_valid = 1'b0;
        @(posedge clock);
        #2;
        check("midrst_strobe_high", 32'(inject_clock), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_strobe", 32'(inject_clock), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_error", 32'(load_error), 32'd0);
        check("midrst_ready", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_writes", 32'(wr_q.size()), 32'd0);

        // A complete good frame after the interrupted one.
        for (int i = 0; i < 4; i++) fdata.push_back(8'($urandom));
        add_frame(8'h00);
        run_stream(1'b0);
        check("final_done", 32'(load_done), 32'd1);
        check("final_hold", 32'(cpu_hold), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ins_loader.md
# ins_loader

Program loader that drives the instruction-memory injection port (`inject_addr`, `inject_data`, `inject_clock`) from a framed byte stream, typically a UART receiver. It sits between the host link and `ins_memory`, and holds the CPU in reset while a program is being written. After the frame checksum verifies, it releases the CPU. It writes one byte per injection strobe into the 1024×8 instruction memory.

## Interface
- `ADDR_WIDTH`, default 10: injection address width; the memory depth is 2^ADDR_WIDTH bytes.
- `MAX_BYTES`, default 1024: largest legal frame payload length.
- `clock`  in  1: single system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; forces the reset state immediately.
- `rx_data`  in  8: incoming byte.
- `rx_valid`  in  1: `rx_data` is valid this cycle.
- `rx_ready`  out  1: loader accepts the byte. A transfer occurs on any edge where `rx_valid` and `rx_ready` are both high.
- `inject_addr`  out  ADDR_WIDTH: byte address to the instruction memory.
- `inject_data`  out  8: byte to write.
- `inject_clock`  out  1: write strobe; the memory writes on its rising edge.
- `cpu_hold`  out  1: high means the CPU is held in reset.
- `load_done`  out  1: the last frame loaded with a good checksum (sticky).
- `load_error`  out  1: the last frame had a bad length or bad checksum (sticky).

## Operation
- Frame format: 0xA5, LEN_LO, LEN_HI, then N data bytes, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = 8-bit sum of the N data bytes, mod 256. The header bytes are not included.
- States: IDLE, LEN_LO, LEN_HI, DATA, SETUP, STROBE, CHECK.
- `rx_ready` = 1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK. `rx_ready` = 0 in SETUP and STROBE.
- IDLE:
  - A byte of 0xA5 moves to LEN_LO. It also clears `load_done` and `load_error` and sets `cpu_hold` = 1.
  - Any other byte is discarded and the state stays IDLE.
- LEN_LO: latch the low length byte, then go to LEN_HI.
- LEN_HI: latch the high length byte.
  - If N == 0 or N > MAX_BYTES: set `load_error` = 1 and return to IDLE. `cpu_hold` stays 1.
  - Otherwise: clear the address counter, byte count and running sum, then go to DATA.
- DATA: on transfer, register `inject_data` = byte and `inject_addr` = counter, add the byte to the sum, then go to SETUP.
- SETUP: `inject_clock` stays 0 for one cycle while addr and data are stable. Go to STROBE.
- STROBE: `inject_clock` = 1 for exactly one cycle. On the exit edge:
  - drive `inject_clock` to 0;
  - increment the counter;
  - go to CHECK if the count equals N, otherwise go back to DATA.
- CHECK: on transfer, compare the byte with the sum.
  - Equal: `load_done` = 1, `cpu_hold` = 0, go to IDLE.
  - Not equal: `load_error` = 1, `cpu_hold` = 1, go to IDLE.
- Inside DATA, 0xA5 is ordinary data. There is no resync within a frame.
- Address arithmetic: counter is ADDR_WIDTH bits and starts at 0. The last address is N−1 (at most 1023), so the counter never wraps within a legal frame.
- Bytes already written are not rolled back on error.

## Timing
- Reset values:
  - state = IDLE;
  - `inject_addr` = 0, `inject_data` = 0, `inject_clock` = 0;
  - `cpu_hold` = 1, `load_done` = 0, `load_error` = 0;
  - `rx_ready` = 1.
- All outputs are registered except `rx_ready`, which decodes combinationally from the state.
- Per data byte:
  - the transfer edge at cycle k updates addr and data;
  - `inject_clock` rises at edge k+1 and falls at edge k+2;
  - the next byte can be accepted at edge k+3.
  - Result: 3 cycles per byte, at least one clock of setup and hold around the strobe.
- `load_done` and `cpu_hold` change on the same edge that accepts a good CHK byte.
- `rx_valid` held high continuously: no byte is lost or duplicated. Bytes are consumed only when `rx_ready` = 1.
- Reset asserted mid-frame: `inject_clock` drops to 0 asynchronously, the state returns to IDLE, and `cpu_hold` = 1.

## Test plan
- Reset check: assert `reset` with random stimulus. Required: every output at its reset value, no `inject_clock` edges, `rx_ready` = 1.
- Good load: send A5 04 00 13 00 00 00 13.
  - Four `inject_clock` pulses at addr 0..3 with data 13, 00, 00, 00.
  - Each pulse has addr and data stable from one cycle before the rise until one cycle after the fall.
  - End state: `load_done` = 1, `cpu_hold` = 0, `load_error` = 0.
- Bad checksum: send A5 01 00 FF 00. Required: one write of FF at addr 0, `load_error` = 1, `cpu_hold` = 1, `load_done` = 0.
- Bad length: send A5 00 00, then A5 01 04 (N = 1025). Required: `load_error` = 1 after each header, zero `inject_clock` pulses, return to IDLE.
- Full-size streaming: garbage 00 FF before A5, then N = 1024, data byte i = i mod 256, `rx_valid` held high.
  - Garbage is ignored.
  - 1024 pulses occur at addr 0..1023, with `rx_ready` low for 2 of every 3 DATA cycles.
  - With CHK = 00: `load_done` = 1.
- Reset mid-load: assert `reset` while in STROBE at byte 2 of a 4-byte frame.
  - Required: `inject_clock` drops to 0 immediately, `cpu_hold` = 1, flags cleared.
  - A following complete good frame then loads correctly.
